// File: rtl/pipe_hazard_tracker_if.sv
// ID-stage hazard interface: decoded operand/destination info in, stall and forward selects out.
interface pipe_hazard_tracker_if #(
  parameter int REG_ADDR_W = 3,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_wr_en;
  logic                  id_is_load;
  logic                  kill;

  logic                  stall;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;
  logic                  busy;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_wr_en, id_is_load, kill,
    input  stall, fwd_a, fwd_b, busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_wr_en, id_is_load, kill,
    output stall, fwd_a, fwd_b, busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_tracker.sv
// In-flight write tracker beside ID: shadows DEPTH post-ID stages, derives load-use
// stall and per-operand forward selects (youngest producer wins).
module pipe_hazard_tracker #(
  parameter int REG_ADDR_W  = 3,
  parameter int DEPTH       = 3,
  parameter int LOAD_READY  = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_tracker_if.slave  hz
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
  } entry_t;

  typedef struct packed {
    logic [FWD_W-1:0] sel;
    logic             ready;
  } lookup_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  lookup_t            look_a, look_b;
  logic               stall;
  logic               busy;

  // Scan oldest to youngest so the youngest matching producer overwrites the result.
  function automatic lookup_t lookup(input entry_t [DEPTH-1:0] ents,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic active);
    lookup_t res;
    res.sel   = '0;
    res.ready = 1'b1;
    if (active && !((ZERO_REG_EN != 0) && (src == '0))) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ents[i].valid && ents[i].wr_en && (ents[i].rd == src)) begin
          res.sel   = FWD_W'(i + 1);
          res.ready = !ents[i].is_load || (i >= LOAD_READY);
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    look_a = lookup(ent_q, hz.id_rs1, hz.id_valid & hz.id_rs1_used);
    look_b = lookup(ent_q, hz.id_rs2, hz.id_valid & hz.id_rs2_used);
    // A killed instruction never waits: kill overrides any hazard.
    stall  = hz.id_valid & ~hz.kill & ~(look_a.ready & look_b.ready);
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | ent_q[i].valid;
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
    ent_d = '0;
    cnt_d = cnt_q;
    for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
    if (hz.id_valid && !hz.kill && !stall) begin
      ent_d[0].valid   = 1'b1;
      ent_d[0].rd      = hz.id_rd;
      ent_d[0].wr_en   = hz.id_wr_en;
      ent_d[0].is_load = hz.id_is_load;
    end
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole shadow is cleared, not only the valid bits, so a reset leaves no stale rd/is_load to chase in waveforms.
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values regardless of statement order.
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.fwd_a     = look_a.sel;
  assign hz.fwd_b     = look_b.sel;
  assign hz.busy      = busy;
  assign hz.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Three configurations share one ID stream: default, CNT_W=4, and DEPTH=5/LOAD_READY=2.
module tb_pipe_hazard_tracker;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load, kill;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;

  always #5 clk = ~clk;

  pipe_hazard_tracker_if #(.REG_ADDR_W(RW), .DEPTH(3), .CNT_W(16)) if0 ();
  pipe_hazard_tracker_if #(.REG_ADDR_W(RW), .DEPTH(3), .CNT_W(4))  if1 ();
  pipe_hazard_tracker_if #(.REG_ADDR_W(RW), .DEPTH(5), .CNT_W(16)) if2 ();

  assign if0.id_valid = id_valid;       assign if1.id_valid = id_valid;       assign if2.id_valid = id_valid;
  assign if0.id_rs1 = id_rs1;           assign if1.id_rs1 = id_rs1;           assign if2.id_rs1 = id_rs1;
  assign if0.id_rs1_used = id_rs1_used; assign if1.id_rs1_used = id_rs1_used; assign if2.id_rs1_used = id_rs1_used;
  assign if0.id_rs2 = id_rs2;           assign if1.id_rs2 = id_rs2;           assign if2.id_rs2 = id_rs2;
  assign if0.id_rs2_used = id_rs2_used; assign if1.id_rs2_used = id_rs2_used; assign if2.id_rs2_used = id_rs2_used;
  assign if0.id_rd = id_rd;             assign if1.id_rd = id_rd;             assign if2.id_rd = id_rd;
  assign if0.id_wr_en = id_wr_en;       assign if1.id_wr_en = id_wr_en;       assign if2.id_wr_en = id_wr_en;
  assign if0.id_is_load = id_is_load;   assign if1.id_is_load = id_is_load;   assign if2.id_is_load = id_is_load;
  assign if0.kill = kill;               assign if1.kill = kill;               assign if2.kill = kill;

  pipe_hazard_tracker #(.REG_ADDR_W(RW), .DEPTH(3), .LOAD_READY(1), .ZERO_REG_EN(1), .CNT_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .hz(if0.slave));
  pipe_hazard_tracker #(.REG_ADDR_W(RW), .DEPTH(3), .LOAD_READY(1), .ZERO_REG_EN(1), .CNT_W(4))
    dut1 (.clk(clk), .rst_n(rst_n), .hz(if1.slave));
  pipe_hazard_tracker #(.REG_ADDR_W(RW), .DEPTH(5), .LOAD_READY(2), .ZERO_REG_EN(1), .CNT_W(16))
    dut2 (.clk(clk), .rst_n(rst_n), .hz(if2.slave));

  // Field value -1 means "don't care".
  typedef struct {
    int    dut;
    string name;
    int    st;
    int    fa;
    int    fb;
    int    by;
    int    cnt;
  } exp_t;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   a_st, a_fa, a_fb, a_by, a_cnt;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.dut)
        0: begin a_st = int'(if0.stall); a_fa = int'(if0.fwd_a); a_fb = int'(if0.fwd_b);
                 a_by = int'(if0.busy);  a_cnt = int'(if0.stall_cnt); end
        1: begin a_st = int'(if1.stall); a_fa = int'(if1.fwd_a); a_fb = int'(if1.fwd_b);
                 a_by = int'(if1.busy);  a_cnt = int'(if1.stall_cnt); end
        default: begin a_st = int'(if2.stall); a_fa = int'(if2.fwd_a); a_fb = int'(if2.fwd_b);
                 a_by = int'(if2.busy);  a_cnt = int'(if2.stall_cnt); end
      endcase
      if (e.st  >= 0) check({e.name, ".stall"},     a_st,  e.st);
      if (e.fa  >= 0) check({e.name, ".fwd_a"},     a_fa,  e.fa);
      if (e.fb  >= 0) check({e.name, ".fwd_b"},     a_fb,  e.fb);
      if (e.by  >= 0) check({e.name, ".busy"},      a_by,  e.by);
      if (e.cnt >= 0) check({e.name, ".stall_cnt"}, a_cnt, e.cnt);
    end
  end

  task automatic push_exp(input int dut, input string name, input int st, input int fa,
                          input int fb, input int by, input int cnt);
    exp_t e;
    e.dut = dut; e.name = name; e.st = st; e.fa = fa; e.fb = fb; e.by = by; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2, input logic [RW-1:0] rd,
                       input logic we, input logic ld, input logic kl);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wr_en = we; id_is_load = ld; kill = kl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then a mid-cycle reset with a load-use pending.
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
    push_exp(0, "rst_state", 0, 0, 0, 0, 0);
    tick();
    drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    #2 rst_n = 1'b0;
    push_exp(0, "t1_async_rst", 0, 0, 0, 0, 0);
    #4 rst_n = 1'b1;
    tick();
    drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    push_exp(0, "t1_after", 0, 0, -1, 1, 0);
    tick();

    // ALU producer forwarded from EXE, MEM, WB, then register file.
    reset_all();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0);
    tick();
    drive(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    push_exp(0, "t2_fwd1", 0, 1, 0, 1, -1);
    tick();
    push_exp(0, "t2_fwd2", 0, 2, 0, 1, -1);
    tick();
    push_exp(0, "t2_fwd3", 0, 3, 0, 1, -1);
    tick();
    push_exp(0, "t2_rf", 0, 0, 0, -1, -1);
    push_exp(2, "t2_d5_fwd4", 0, 4, -1, 1, -1);
    tick();

    // Load-use on rs2: one stall, then forward from MEM.
    reset_all();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
    tick();
    drive(1, 3'd0, 0, 3'd5, 1, 3'd1, 1, 0, 0);
    push_exp(0, "t3_stall", 1, 0, 1, 1, 0);
    tick();
    push_exp(0, "t3_fwd", 0, 0, 2, 1, 1);
    tick();
    idle();
    push_exp(0, "t3_cnt", 0, 0, 0, 1, 1);
    tick();

    // Two writers of r4: youngest wins on both operands.
    reset_all();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0);
    tick();
    tick();
    drive(1, 3'd4, 1, 3'd4, 1, 3'd0, 0, 0, 0);
    push_exp(0, "t4_young", 0, 1, 1, 1, -1);
    tick();

    // Zero register never depends; kill beats a load-use hazard and leaves a bubble.
    reset_all();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0);
    tick();
    drive(1, 3'd0, 1, 3'd0, 0, 3'd6, 1, 1, 0);
    push_exp(0, "t5_zero", 0, 0, 0, 1, -1);
    tick();
    drive(1, 3'd6, 1, 3'd0, 0, 3'd7, 1, 0, 1);
    push_exp(0, "t5_kill", 0, 1, 0, 1, 0);
    tick();
    drive(1, 3'd6, 1, 3'd7, 1, 3'd0, 0, 0, 0);
    push_exp(0, "t5_bubble", 0, 2, 0, 1, 0);
    tick();

    // Repeated load-use (lw r5,(r5)) stalls every other cycle; narrow counter saturates.
    reset_all();
    for (int i = 1; i <= 40; i++) begin
      drive(1, 3'd5, 1, 3'd0, 0, 3'd5, 1, 1, 0);
      if (i == 29) push_exp(1, "t6_cnt14", -1, -1, -1, -1, 14);
      if (i == 30) push_exp(0, "t6_stall_even", 1, 1, -1, 1, -1);
      if (i == 31) push_exp(1, "t6_cnt15", 0, 2, -1, -1, 15);
      tick();
    end
    idle();
    push_exp(1, "t6_sat", 0, -1, -1, -1, 15);
    push_exp(0, "t6_cnt20", 0, -1, -1, -1, 20);
    tick();

    // DEPTH=5, LOAD_READY=2: two stall cycles, then forward select 3.
    reset_all();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
    tick();
    drive(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
    push_exp(2, "t6b_stall1", 1, 0, 1, 1, 0);
    tick();
    push_exp(2, "t6b_stall2", 1, 0, 2, 1, 1);
    tick();
    push_exp(2, "t6b_fwd3", 0, 0, 3, 1, 2);
    tick();
    idle();
    push_exp(2, "t6b_done", 0, 0, 0, 1, 2);
    tick();

    @(negedge clk);
    #1;
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
